// File: rtl/rng_pkg.sv
// rng_pkg: shared state type and constants for the ring-oscillator scheduler
package rng_pkg;
    localparam int RNG_BITS = 5;
    localparam int FCNT_W = 8;
    typedef enum logic [1:0] {RING_RST, WARMUP, FILL, READY} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first active request at or after ptr in cyclic order
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] sel,
    output logic [IW-1:0]   idx
);
    always_comb begin
        idx = ptr;
        // walk from the farthest offset down so the nearest active request wins
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % NREQ]) idx = IW'((int'(ptr) + i) % NREQ);
        sel = '0;
        sel[idx] = |req;
    end
endmodule

// File: rtl/rng_sched.sv
// rng_sched: ring RNG bring-up, repetition health test and round-robin word dispatch
module rng_sched
    import rng_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WORD_W = 16,
    parameter int RING_RST_CYC = 8,
    parameter int WARMUP_CYC = 64,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ring_reset,
    input  logic [RNG_BITS-1:0] rng_in,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     gnt,
    output logic [WORD_W-1:0]   rnd_data,
    output logic                word_valid,
    output logic                fault,
    output logic [FCNT_W-1:0]   fault_cnt
);
    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(WORD_W + 1);
    state_t state, state_n;
    logic [RNG_BITS-1:0] sync1, sync2;
    logic [15:0] cnt;
    logic [BW-1:0] bit_cnt;
    logic [7:0] rep_cnt, rep_n;
    logic [WORD_W-1:0] word;
    logic [IW-1:0] rr_ptr, idx;
    logic [NREQ-1:0] sel;
    logic bit_s, prev_bit, pulse, rep_fail, word_done, enter_fill;

    rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req), .ptr(rr_ptr), .sel(sel), .idx(idx));

    assign bit_s = ^sync2;
    assign pulse = state == FILL && cnt == 16'(SAMPLE_DIV - 1);
    // rep_cnt of zero marks the first sample of a fill, which has no predecessor
    assign rep_n = (rep_cnt == 8'd0 || bit_s != prev_bit) ? 8'd1 : rep_cnt + 8'd1;
    assign rep_fail = pulse && rep_n == 8'(REP_LIMIT);
    assign word_done = pulse && bit_cnt == BW'(WORD_W - 1);
    assign enter_fill = state_n == FILL && state != FILL;
    assign ring_reset = state == RING_RST;
    assign word_valid = state == READY;

    always_comb begin
        state_n = state;
        case (state)
            RING_RST: state_n = cnt == 16'(RING_RST_CYC - 1) ? WARMUP : RING_RST;
            WARMUP:   state_n = cnt == 16'(WARMUP_CYC - 1) ? FILL : WARMUP;
            FILL:     state_n = rep_fail ? RING_RST : word_done ? READY : FILL;
            READY:    state_n = |req ? FILL : READY;
            default:  state_n = RING_RST;
        endcase
    end

    always_ff @(posedge clk)
        if (reset) state <= RING_RST;
        else state <= state_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cnt <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            prev_bit <= 1'b0;
            word <= '0;
            gnt <= '0;
            rnd_data <= '0;
            fault <= 1'b0;
            fault_cnt <= '0;
            rr_ptr <= '0;
        end else begin
            sync1 <= rng_in;
            sync2 <= sync1;
            gnt <= '0;
            fault <= 1'b0;
            // one counter times every phase; it restarts on each state change and sample
            cnt <= (state_n != state || pulse) ? '0 : cnt + 16'd1;
            if (enter_fill) begin
                bit_cnt <= '0;
                rep_cnt <= '0;
            end else if (pulse) begin
                bit_cnt <= bit_cnt + BW'(1);
                rep_cnt <= rep_n;
                prev_bit <= bit_s;
                word <= {word[WORD_W-2:0], bit_s};
            end
            if (rep_fail) begin
                fault <= 1'b1;
                fault_cnt <= fault_cnt + FCNT_W'(~&fault_cnt);
            end
            if (state == READY && |req) begin
                gnt <= sel;
                rnd_data <= word;
                rr_ptr <= idx == IW'(NREQ - 1) ? '0 : idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rng_sched.sv
// tb_rng_sched: random-stimulus bench for rng_sched against a timeline reference model
module tb_rng_sched;
    localparam int N = 4, W = 16, RST_C = 8, WARM_C = 64, DIV = 4, REP = 8;
    logic clk = 1'b0, reset = 1'b1, ring_reset, word_valid, fault;
    logic [4:0] rng_in = '0;
    logic [N-1:0] req = '0, gnt;
    logic [W-1:0] rnd_data;
    logic [7:0] fault_cnt;

    rng_sched #(.NREQ(N), .WORD_W(W), .RING_RST_CYC(RST_C), .WARMUP_CYC(WARM_C),
                .SAMPLE_DIV(DIV), .REP_LIMIT(REP)) dut (
        .clk(clk), .reset(reset), .ring_reset(ring_reset), .rng_in(rng_in), .req(req),
        .gnt(gnt), .rnd_data(rnd_data), .word_valid(word_valid), .fault(fault),
        .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, c = 0;
    logic [4:0] hist [0:65535];
    // source: 0 random, 1 random values with slowly alternating parity, 2 stuck at zero
    int src_mode = 0;
    logic [N-1:0] req_pat = '0;
    bit req_fill_only = 1'b0;
    // model: t0 = bring-up start cycle, fill_t0 = cycle the current fill starts
    bit on = 1'b0, ready = 1'b0, last = 1'b0, m_fault = 1'b0;
    int t0 = 0, fill_t0 = 0, nbits = 0, rep = 0, ptr = 0, fcnt = 0;
    logic [W-1:0] word = '0, m_data = '0;
    logic [N-1:0] m_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    task automatic tick(input bit rst = 1'b0);
        logic [4:0] x;
        int k;
        bit b;
        @(posedge clk);
        #1;
        c++;
        x = 5'($urandom);
        if (src_mode == 1 && (^x) != ((c / 8) % 2 == 1)) x[0] = ~x[0];
        if (src_mode == 2) x = '0;
        rng_in = x;
        hist[c] = x;
        reset = rst;
        req = req_fill_only ? ((!ready && c >= fill_t0) ? N'(4) : '0) : req_pat;
        if (on) begin
            chk("ring_reset", ring_reset, c - t0 < RST_C);
            chk("word_valid", word_valid, ready);
            chk("gnt", gnt, m_gnt);
            chk("rnd_data", rnd_data, m_data);
            chk("fault", fault, m_fault);
            chk("fault_cnt", fault_cnt, fcnt);
        end
        m_gnt = '0;
        m_fault = 1'b0;
        if (rst) begin
            on = 1'b1;
            t0 = c + 1;
            fill_t0 = c + 1 + RST_C + WARM_C;
            ready = 1'b0;
            nbits = 0;
            ptr = 0;
            fcnt = 0;
            m_data = '0;
        end else if (ready && req != '0) begin
            k = ptr;
            while (!req[k]) k = (k + 1) % N;
            m_gnt[k] = 1'b1;
            m_data = word;
            ptr = (k + 1) % N;
            ready = 1'b0;
            fill_t0 = c + 1;
            nbits = 0;
        end else if (!ready && c >= fill_t0 && (c - fill_t0) % DIV == DIV - 1) begin
            b = ^hist[c-2];
            rep = (nbits == 0 || b != last) ? 1 : rep + 1;
            last = b;
            nbits++;
            word = {word[W-2:0], b};
            if (rep == REP) begin
                m_fault = 1'b1;
                fcnt = fcnt == 255 ? 255 : fcnt + 1;
                t0 = c + 1;
                fill_t0 = c + 1 + RST_C + WARM_C;
                nbits = 0;
            end else if (nbits == W) ready = 1'b1;
        end
    endtask

    task automatic wait_gnt(input string tag, output logic [N-1:0] g);
        g = '0;
        for (int i = 0; i < 3000 && g == '0; i++) begin
            tick();
            g = gnt;
        end
        if (g == '0) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic bringup(input string tag);
        int rel, fall, vld;
        fall = -1;
        vld = -1;
        tick(1'b1);
        rel = c + 1;
        tick();
        chk({tag, "_rst_ring_reset"}, ring_reset, 1);
        chk({tag, "_rst_gnt"}, gnt, 0);
        chk({tag, "_rst_rnd_data"}, rnd_data, 0);
        chk({tag, "_rst_word_valid"}, word_valid, 0);
        chk({tag, "_rst_fault"}, fault, 0);
        chk({tag, "_rst_fault_cnt"}, fault_cnt, 0);
        for (int i = 0; i < 400 && vld < 0; i++) begin
            tick();
            if (fall < 0 && !ring_reset) fall = c - rel;
            if (word_valid) vld = c - rel;
        end
        chk({tag, "_ring_fall"}, fall, RST_C);
        chk({tag, "_first_valid"}, vld, RST_C + WARM_C + W * DIV);
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] rr_exp [5];
        int n, gc, nf;
        bit f;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        repeat (3) tick(1'b1);
        src_mode = 1;
        bringup("boot");

        src_mode = 0;
        req_pat = '1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt("rr", g);
            chk($sformatf("rr_order%0d", i), g, rr_exp[i]);
        end
        req_pat = 4'b1001;
        wait_gnt("skip", g);
        chk("skip_first", g, 4'b1000);
        wait_gnt("skip", g);
        chk("skip_wrap", g, 4'b0001);
        req_pat = '0;

        src_mode = 1;
        req_fill_only = 1'b1;
        n = 0;
        for (int i = 0; i < 350; i++) begin
            tick();
            n += int'(gnt != '0);
        end
        chk("withdraw_no_gnt", n, 0);
        chk("withdraw_valid_held", word_valid, 1);
        req_fill_only = 1'b0;
        req_pat = 4'b0010;
        wait_gnt("withdraw", g);
        chk("withdraw_late_gnt", g, 4'b0010);
        req_pat = '0;

        repeat (W * DIV / 2) tick();
        bringup("mid");

        src_mode = 2;
        req_pat = 4'b0001;
        wait_gnt("stuck", g);
        gc = c;
        req_pat = '0;
        f = 1'b0;
        for (int i = 0; i < 200 && !f; i++) begin
            tick();
            f = fault;
        end
        chk("stuck_fault_seen", f, 1);
        chk("stuck_latency", c - gc, DIV * REP);
        chk("stuck_fault_cnt", fault_cnt, 1);
        chk("stuck_ring_reset", ring_reset, 1);
        nf = 1;
        for (int i = 0; i < 40000 && nf < 300; i++) begin
            tick();
            nf += int'(fault);
        end
        chk("stuck_nfaults", nf, 300);
        chk("stuck_saturate", fault_cnt, 255);
        tick();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/rng_sched.md
# rng_sched

Controller and arbiter for the ring-oscillator random source. Drives the ring's start-up reset, brings its asynchronous 5-bit output into the system clock domain, and discards a warm-up interval. It then packs sampled bits into words, runs a repetition health test, and hands each word to exactly one of NREQ requesters in round-robin order. It sits between the ring_rnd instance and its consumers, so no two consumers ever receive the same random data.

## Interface
- NREQ, 4: number of requesters, 2..8
- WORD_W, 16: output word width in bits
- RING_RST_CYC, 8: cycles ring_reset is held after reset releases
- WARMUP_CYC, 64: cycles after ring release during which samples are discarded
- SAMPLE_DIV, 4: clk cycles between bit samples, ≥3
- REP_LIMIT, 8: consecutive identical sampled bits that count as a fault, 2..255
- clk  in  1  system clock; only clock of the block
- reset  in  1  synchronous, active-high reset
- ring_reset  out  1  to ring_rnd.reset; high restarts the oscillators
- rng_in  in  5  ring_rnd.rng_out, asynchronous to clk
- req  in  NREQ  level request per requester; held until granted, may drop earlier
- gnt  out  NREQ  one-hot, one-cycle pulse; rnd_data is valid in that cycle
- rnd_data  out  WORD_W  granted word
- word_valid  out  1  a full word is waiting for a requester
- fault  out  1  one-cycle pulse when the health test fails
- fault_cnt  out  8  saturating count of health faults since reset

## Operation
- rng_in passes through a 2-flop synchroniser per bit. The sampled bit is the XOR-reduce of the synchronised 5-bit vector.
- FSM states: RING_RST, WARMUP, FILL, READY.
- RING_RST: ring_reset=1. A counter runs RING_RST_CYC cycles, then the FSM moves to WARMUP.
- WARMUP: ring_reset=0. A counter runs WARMUP_CYC cycles with no samples kept, then the FSM moves to FILL with the bit count and repetition count cleared.
- FILL: a divider pulses every SAMPLE_DIV cycles. Each pulse shifts the sampled bit into the LSB of the word shift register. After WORD_W samples the FSM moves to READY.
- Repetition test, in FILL only:
  - rep_cnt resets to 1 when the new bit differs from the previous bit, and increments when it is equal.
  - When rep_cnt reaches REP_LIMIT, fault pulses, fault_cnt increments (saturating at 255), the partial word is discarded, and the FSM moves to RING_RST.
- READY: word_valid=1 and sampling is paused. When req≠0, the requester at or after rr_ptr in cyclic order is selected.
  - Next cycle: gnt for that requester, rnd_data=word, rr_ptr becomes the granted index + 1 mod NREQ, FSM moves to FILL with counters cleared.
- Only one grant per word. A word is never reissued.
- Requests arriving outside READY wait. Dropping a req before grant is legal and loses nothing.

## Timing
- Reset values:
  - ring_reset=1, gnt=0, rnd_data=0, word_valid=0, fault=0, fault_cnt=0, rr_ptr=0, FSM=RING_RST.
  - The RING_RST counter starts at the first cycle with reset low.
- ring_reset falls RING_RST_CYC cycles after reset release.
- The first FILL cycle is RING_RST_CYC+WARMUP_CYC cycles after reset release.
- First word_valid: WORD_W×SAMPLE_DIV cycles after FILL entry; the first sample pulse occurs at SAMPLE_DIV cycles into FILL.
- Grant latency: 1 cycle from the first READY cycle in which req≠0. word_valid drops in the gnt cycle.
- rnd_data holds its last granted value between grants.
- Refill after a grant takes WORD_W×SAMPLE_DIV cycles; sample phase restarts at 0.
- Health fault:
  - fault pulses in the cycle after the failing sample.
  - ring_reset rises in that same cycle, and the full RING_RST and WARMUP sequence repeats.
- Reset asserted in any state returns to reset values next cycle. Partial and ready words are lost and fault_cnt is cleared.
- A req change in the same cycle as READY entry is evaluated in that cycle.

## Structure
- Shared package rng_pkg holds:
  - the FSM state enum (RING_RST, WARMUP, FILL, READY);
  - the RNG_BITS=5 constant;
  - the fault counter width constant.
- One sub-module, rr_arbiter (NREQ, req, rr_ptr → one-hot select + index). It is reused by other shared-resource controllers.

## Test plan
- Reset and bring-up: NREQ=4, defaults, rng_in driven by a random model. ring_reset must be high for exactly 8 cycles after reset release, FILL must begin at cycle 72, and the first word_valid must appear at cycle 136.
- Round robin: req=4'b1111 held continuously. Grants must occur in order 0001, 0010, 0100, 1000, 0001, one per word, and each rnd_data must equal the model-packed bits.
- Stuck source: rng_in held at 5'b00000. fault must pulse after 8 samples, fault_cnt must read 1, and ring_reset must go high again. After 300 repeats fault_cnt must saturate at 255.
- Skip idle requester: rr_ptr=1, req=4'b1001. The grant must go to 3, and the next grant to 0.
- Request withdraw: req[2] pulses high only during FILL, and no other requests are present. No gnt may occur, and word_valid must stay high until a later req.
- Mid-operation reset: reset is asserted for 1 cycle halfway through FILL. All outputs must return to reset values and the bring-up timing from the first scenario must repeat exactly.
